wr_fifo_byte_packer: RTL and testbench

WR_FIFO_BYTE_PACKER -- requirements
Module: wr_fifo_byte_packer

---
 rtl/wr_fifo_byte_packer.sv | 76 +++++++
 tb/tb_wr_fifo_byte_packer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wr_fifo_byte_packer.sv
// wr_fifo_byte_packer: packs a byte stream little-endian into 32-bit FIFO words with byte enables.
// Ports: wr_clk/wr_rst (sync, active-low) clock and reset; s_data/s_valid/s_last/s_ready upstream byte stream;
//        wr_full/almost_full FIFO flags; fifo_wr_data/fifo_wr_en/fifo_wr_byte_en FIFO write side;
//        pkt_cnt packets fully written to the FIFO (wraps).
module wr_fifo_byte_packer #(
    parameter logic c_AF_THROTTLE = 1'b0
) (
    input  logic        wr_clk,
    input  logic        wr_rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        wr_full,
    input  logic        almost_full,
    output logic [31:0] fifo_wr_data,
    output logic        fifo_wr_en,
    output logic [3:0]  fifo_wr_byte_en,
    output logic [15:0] pkt_cnt
);
    logic [1:0]  byte_cnt;
    logic [31:0] acc;
    logic [31:0] pend_data;
    logic [3:0]  pend_be;
    logic        pend_last;
    logic        pend_vld;
    logic        stall;
    logic        accept;
    logic        complete;
    logic [31:0] word;

    assign stall           = wr_full | (c_AF_THROTTLE & almost_full);
    assign fifo_wr_en      = pend_vld & ~stall;
    // a draining pending word frees the register in the same cycle a new word may complete
    assign s_ready         = ~pend_vld | ~stall;
    assign accept          = s_valid & s_ready;
    assign complete        = accept & ((byte_cnt == 2'd3) | s_last);
    assign fifo_wr_data    = pend_data;
    assign fifo_wr_byte_en = pend_be;

    // lanes above the current byte stay 0 because acc is cleared on every completion
    always_comb begin
        word = acc;
        word[{byte_cnt, 3'b000} +: 8] = s_data;
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            byte_cnt  <= '0;
            acc       <= '0;
            pend_data <= '0;
            pend_be   <= '0;
            pend_last <= 1'b0;
            pend_vld  <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            if (accept) begin
                byte_cnt <= complete ? 2'd0 : byte_cnt + 2'd1;
                acc      <= complete ? 32'd0 : word;
            end
            if (complete) begin
                pend_data <= word;
                pend_be   <= ~(4'b1110 << byte_cnt);
                pend_last <= s_last;
                pend_vld  <= 1'b1;
            end else if (fifo_wr_en) begin
                pend_data <= '0;
                pend_be   <= '0;
                pend_last <= 1'b0;
                pend_vld  <= 1'b0;
            end
            if (fifo_wr_en && pend_last)
                pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wr_fifo_byte_packer.sv
// tb_wr_fifo_byte_packer: scoreboard bench for wr_fifo_byte_packer with directed vectors.
module tb_wr_fifo_byte_packer;
    logic        wr_clk = 1'b0;
    logic        wr_rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        wr_full;
    logic        almost_full;
    logic        s_ready, fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [3:0]  fifo_wr_byte_en;
    logic [15:0] pkt_cnt;
    logic        s_ready0, fifo_wr_en0;
    logic [31:0] fifo_wr_data0;
    logic [3:0]  fifo_wr_byte_en0;
    logic [15:0] pkt_cnt0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 wr_clk = ~wr_clk;
    always @(posedge wr_clk) cyc++;

    wr_fifo_byte_packer #(.c_AF_THROTTLE(1'b1)) u1 (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .wr_full(wr_full), .almost_full(almost_full), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_byte_en(fifo_wr_byte_en), .pkt_cnt(pkt_cnt)
    );

    wr_fifo_byte_packer #(.c_AF_THROTTLE(1'b0)) u0 (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready0), .wr_full(wr_full), .almost_full(almost_full), .fifo_wr_data(fifo_wr_data0),
        .fifo_wr_en(fifo_wr_en0), .fifo_wr_byte_en(fifo_wr_byte_en0), .pkt_cnt(pkt_cnt0)
    );

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back('{data: d, be: be});
    endtask

    // call at posedge+#1; returns at posedge+#1 after the byte has been accepted
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        s_data = d; s_valid = 1'b1; s_last = l; n = 0;
        @(negedge wr_clk);
        while (!s_ready && n < 50) begin
            @(negedge wr_clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end
        @(posedge wr_clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    always @(negedge wr_clk) begin
        if (fifo_wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got %h/%b expected no write", fifo_wr_data, fifo_wr_byte_en);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({fifo_wr_data, fifo_wr_byte_en} !== {e.data, e.be}) begin
                    bad++;
                    $display("FAIL write_word: got %h/%b expected %h/%b", fifo_wr_data, fifo_wr_byte_en, e.data, e.be);
                end
            end
        end
    end

    initial begin
        int t0;
        wr_rst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; wr_full = 1'b0; almost_full = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        check("rst_s_ready", 36'(s_ready), 36'd1);
        check("rst_wr_en", 36'(fifo_wr_en), 36'd0);
        check("rst_data", 36'(fifo_wr_data), 36'd0);
        check("rst_be", 36'(fifo_wr_byte_en), 36'd0);
        check("rst_pkt_cnt", 36'(pkt_cnt), 36'd0);
        wr_rst = 1'b1;
        @(posedge wr_clk); #1;

        push(32'h44332211, 4'b1111);
        push(32'h88776655, 4'b1111);
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), i == 8);
        check("stream_cycles", 36'(cyc - t0), 36'd8);
        repeat (2) @(posedge wr_clk);
        #1;
        check("stream_pkt_cnt", 36'(pkt_cnt), 36'd1);

        push(32'h00CCBBAA, 4'b0111);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        push(32'h000000DD, 4'b0001);
        send(8'hDD, 1'b1);
        repeat (2) @(posedge wr_clk);
        #1;
        check("partial_pkt_cnt", 36'(pkt_cnt), 36'd3);

        wr_full = 1'b1;
        push(32'h0000005A, 4'b0001);
        send(8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            check("stall_wr_en", 36'(fifo_wr_en), 36'd0);
            check("stall_s_ready", 36'(s_ready), 36'd0);
            check("stall_data", {fifo_wr_byte_en, fifo_wr_data}, {4'b0001, 32'h0000005A});
        end
        @(posedge wr_clk); #1;
        wr_full = 1'b0;
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        check("stall_single_write", 36'(fifo_wr_en), 36'd0);
        @(posedge wr_clk); #1;

        almost_full = 1'b1;
        push(32'h000000C3, 4'b0001);
        send(8'hC3, 1'b1);
        @(negedge wr_clk);
        check("af_throttle_on", 36'(fifo_wr_en), 36'd0);
        check("af_throttle_off", 36'(fifo_wr_en0), 36'd1);
        @(negedge wr_clk);
        check("af_hold_wr_en", 36'(fifo_wr_en), 36'd0);
        check("af_hold_s_ready", 36'(s_ready), 36'd0);
        @(posedge wr_clk); #1;
        almost_full = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;

        send(8'h01, 1'b0); send(8'h02, 1'b0);
        wr_rst = 1'b0;
        @(posedge wr_clk); #1;
        wr_rst = 1'b1;
        check("rst_mid_pkt_cnt", 36'(pkt_cnt), 36'd0);
        push(32'h04030201, 4'b1111);
        for (int i = 1; i <= 4; i++) send(8'(i), i == 4);
        repeat (2) @(posedge wr_clk);
        #1;
        check("after_rst_pkt_cnt", 36'(pkt_cnt), 36'd1);

        wr_full = 1'b1;
        send(8'h99, 1'b1);
        wr_rst = 1'b0;
        @(posedge wr_clk); #1;
        wr_rst = 1'b1; wr_full = 1'b0;
        @(negedge wr_clk);
        check("rst_stall_drop", 36'(fifo_wr_en), 36'd0);
        @(negedge wr_clk);
        check("rst_stall_drop2", 36'(fifo_wr_en), 36'd0);
        @(posedge wr_clk); #1;

        for (int i = 0; i < 65535; i++) begin
            push({24'd0, 8'(i)}, 4'b0001);
            send(8'(i), 1'b1);
        end
        repeat (2) @(posedge wr_clk);
        #1;
        check("wrap_pre", 36'(pkt_cnt), 36'h0FFFF);
        push(32'h000000EE, 4'b0001);
        send(8'hEE, 1'b1);
        repeat (2) @(posedge wr_clk);
        #1;
        check("wrap_zero", 36'(pkt_cnt), 36'd0);
        check("queue_drained", 36'(exp_q.size()), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
